// File: rtl/sseg_serial_driver.sv
// Serial driver for a chain of 74HC595 seven-segment shift registers.
// Shifts a WIDTH-bit frame MSB-first on a divided serial clock, then pulses the latch enable.
module sseg_serial_driver #(
  parameter int WIDTH = 64,
  parameter int DIV   = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_start,
  input  logic [WIDTH-1:0] i_par_data,
  output logic             o_s_clk,
  output logic             o_s_data,
  output logic             o_s_pen,
  output logic             o_s_clrn,
  output logic             o_busy,
  output logic             o_done
);

  localparam int PH_W  = $clog2(2*WIDTH+2);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST   = DIV_W'(DIV-1);
  localparam logic [PH_W-1:0]  PH_SH_LAST = PH_W'(2*WIDTH-1);
  localparam logic [PH_W-1:0]  PH_LA_LAST = PH_W'(2*WIDTH+1);

  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_LATCH} state_t;

  state_t           r_state, w_state_nxt;
  logic [DIV_W-1:0] r_div,   w_div_nxt;
  logic [PH_W-1:0]  r_phase, w_phase_nxt;
  logic [WIDTH-1:0] r_shreg, w_shreg_nxt;
  logic             w_wrap;
  logic             w_s_clk_nxt, w_s_data_nxt, w_s_pen_nxt, w_busy_nxt, w_done_nxt;

  assign w_wrap = (r_div == DIV_LAST);

  // NOTE: sequential state uses non-blocking (<=) so every register samples pre-edge values.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_phase <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_phase <= w_phase_nxt;
    end
  end

  // NOTE: the shift register is pure datapath, reloaded on every accept, so it carries no reset.
  always_ff @(posedge i_clk) begin
    r_shreg <= w_shreg_nxt;
  end

  // NOTE: every comb output gets a default first, so no path can infer a latch.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_phase_nxt = r_phase;
    w_shreg_nxt = r_shreg;
    case (r_state)
      S_IDLE: begin
        w_div_nxt   = '0;
        w_phase_nxt = '0;
        if (i_start) begin
          w_state_nxt = S_SHIFT;
          w_shreg_nxt = i_par_data;
        end
      end
      S_SHIFT, S_LATCH: begin
        w_div_nxt = w_wrap ? '0 : r_div + DIV_W'(1);
        if (w_wrap) begin
          w_phase_nxt = r_phase + PH_W'(1);
          // The next bit is presented once the high half of the current bit ends.
          if (r_state == S_SHIFT && r_phase[0])
            w_shreg_nxt = r_shreg << 1;
          if (r_state == S_SHIFT && r_phase == PH_SH_LAST)
            w_state_nxt = S_LATCH;
          if (r_state == S_LATCH && r_phase == PH_LA_LAST)
            w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Outputs are decoded from next-state values and then registered.
  always_comb begin
    w_s_clk_nxt  = 1'b0;
    w_s_data_nxt = 1'b0;
    w_s_pen_nxt  = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = (r_state == S_LATCH) && w_wrap && (r_phase == PH_LA_LAST);
    case (w_state_nxt)
      S_SHIFT: begin
        w_busy_nxt   = 1'b1;
        w_s_clk_nxt  = w_phase_nxt[0];
        w_s_data_nxt = w_shreg_nxt[WIDTH-1];
      end
      S_LATCH: begin
        w_busy_nxt  = 1'b1;
        w_s_pen_nxt = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_s_clk  <= 1'b0;
      o_s_data <= 1'b0;
      o_s_pen  <= 1'b0;
      o_s_clrn <= 1'b0;
      o_busy   <= 1'b0;
      o_done   <= 1'b0;
    end else begin
      o_s_clk  <= w_s_clk_nxt;
      o_s_data <= w_s_data_nxt;
      o_s_pen  <= w_s_pen_nxt;
      o_s_clrn <= 1'b1;
      o_busy   <= w_busy_nxt;
      o_done   <= w_done_nxt;
    end
  end

endmodule
